sobel_mdc_tcdm_responder: RTL and testbench
===========================================

// Module: sobel_mdc_tcdm_responder
// PURPOSE
//  TCDM slave (responder) model for the Sobel MDC HWPE's MP TCDM master ports: the memory end of the req/gnt/r_valid protocol.
//  Single-port word memory shared by all ports; round-robin grants, one access per cycle, fixed 1-cycle response.
//  Used in block/cluster benches in place of the cluster TCDM; also flags out-of-range accesses.
// PARAMETERS
//  MP          3            number of TCDM ports served
//  MEM_WORDS   1024         memory depth in 32-bit words (power of 2)
//  BASE_ADDR   32'h1000_0000 byte address of word 0
//  ERR_DATA    32'hDEAD_BEEF read data returned for out-of-range reads
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          reset, synchronous, active-low
//  clear_i        in   1          sync clear of err_o, rr pointer, response pipe
//  tcdm_req_i     in   MP         per-port request
//  tcdm_gnt_o     out  MP         per-port grant (combinational from req, rr_q, stall)
//  tcdm_add_i     in   MPx32      byte address
//  tcdm_wen_i     in   MP         1 = read, 0 = write
//  tcdm_be_i      in   MPx4       byte enables (writes only)
//  tcdm_data_i    in   MPx32      write data
//  tcdm_r_data_o  out  MPx32      read data
//  tcdm_r_valid_o out  MP         response valid
//  err_o          out  1          sticky out-of-range flag
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): r_valid=0, r_data=0, rr_q=0, err_o=0, stall LFSR=seed 16'hACE1. Memory array not reset.
//  - Arbitration: candidates = req & ~stall. Grant the first requesting port p scanning rr_q, rr_q+1, ... mod MP; at most one gnt bit high.
//    On grant: rr_q <= (p+1) mod MP. No grant: rr_q holds.
//  - Handshake: a transfer occurs when req[p] && gnt[p]. Master holds add/wen/be/data stable until granted (not checked).
//  - Addressing: idx = (add - BASE_ADDR) >> 2; in range iff add >= BASE_ADDR and idx < MEM_WORDS; add[1:0] ignored.
//  - Write (wen=0, in range): per byte b with be[b]=1, mem[idx][8b+:8] <= data[8b+:8] at the grant edge. be=0 -> no change.
//  - Read (wen=1, in range): r_data[p] = mem[idx] as of the grant cycle (read-before-write; only one access/cycle, no hazard).
//  - Response: r_valid[p] pulses exactly 1 cycle, the cycle after the grant, for reads and writes. r_data[p] for writes = 0.
//    r_data of non-responding ports holds its previous value. Latency grant->r_valid = 1 cycle; throughput 1 access/cycle total.
//  - Out of range: still granted; write discarded; read returns ERR_DATA; err_o <= 1 (sticky until clear_i or reset).
//  - clear_i: rr_q <= 0, err_o <= 0, pending r_valid dropped (0 next cycle); gnt forced 0 in the clear cycle. Memory kept.
//  - Simultaneous clear_i and grant: clear wins, no access performed, no response.
//  - Reset mid-operation: in-flight response discarded; r_valid=0 the cycle after reset.
// CONFIGURATION
//  TCDM_RESP_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances each cycle; stall=1 when lfsr[2:0]==0
//    (~1/8 of cycles) -> gnt all 0 that cycle, rr_q holds. Exercises master back-pressure.
//  Not defined: stall tied 0; a request is granted in the same cycle whenever it wins arbitration.
// TESTING
//  1 Single write+read: port0 wr add=BASE+0x10 data=32'h1234_5678 be=4'hF, then rd -> r_valid[0] 1 cycle after gnt, r_data=32'h1234_5678.
//  2 Byte enables: mem=32'hFFFF_FFFF, write data=0 be=4'b0101 -> readback 32'hFF00_FF00.
//  3 Round-robin: all 3 ports request reads continuously -> gnt order 0,1,2,0,1,2; each port's r_valid one cycle after its gnt.
//  4 Out of range: read add=BASE+4*MEM_WORDS -> gnt, r_data=32'hDEAD_BEEF, err_o=1 next cycle; clear_i -> err_o=0.
//  5 Clear/reset mid-op: grant issued, rst_ni=0 next edge -> r_valid=0, rr_q=0; clear_i with req -> gnt=0, no memory change.
//  6 TCDM_RESP_STALL_EN: 1000-cycle continuous req on port1 -> gnt duty 80-95%, no r_valid without a preceding grant.

Source files
------------

// File: rtl/sobel_mdc_tcdm_responder.sv
// TCDM responder for the Sobel MDC HWPE: shared single-port word memory, round-robin grants, 1-cycle response.
// Define TCDM_RESP_STALL_EN to add LFSR-driven pseudo-random grant stalls (master back-pressure).
module sobel_mdc_tcdm_responder #(
  parameter int unsigned MP        = 3,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [MP-1:0]        tcdm_req_i,
  output logic [MP-1:0]        tcdm_gnt_o,
  input  logic [MP-1:0][31:0]  tcdm_add_i,
  input  logic [MP-1:0]        tcdm_wen_i,
  input  logic [MP-1:0][3:0]   tcdm_be_i,
  input  logic [MP-1:0][31:0]  tcdm_data_i,
  output logic [MP-1:0][31:0]  tcdm_r_data_o,
  output logic [MP-1:0]        tcdm_r_valid_o,
  output logic                 err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;

  logic [31:0]   mem [MEM_WORDS];
  logic [PW-1:0] rr_q;
  logic [PW-1:0] win_idx;
  logic          win_valid;
  logic          stall;
  logic [MP-1:0] cand;
  logic [31:0]   sel_add;
  logic [31:0]   sel_data;
  logic [3:0]    sel_be;
  logic          sel_wen;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          mem_we;

`ifdef TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; a stall hits whenever the low three bits are all zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (lfsr_q[2:0] == 3'd0);
`else
  assign stall = 1'b0;
`endif

  function automatic logic [PW-1:0] rr_port(input logic [PW-1:0] base, input int unsigned k);
    int unsigned s;
    s = (32'(base) + k) % MP;
    return PW'(s);
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    tcdm_gnt_o = '0;
    cand       = tcdm_req_i & {MP{~stall}};
    if (rst_ni && !clear_i) begin
      for (int unsigned k = 0; k < MP; k++) begin
        if (!win_valid && cand[rr_port(rr_q, k)]) begin
          win_valid = 1'b1;
          win_idx   = rr_port(rr_q, k);
        end
      end
    end
    if (win_valid) tcdm_gnt_o[win_idx] = 1'b1;
  end

  assign sel_add  = tcdm_add_i[win_idx];
  assign sel_data = tcdm_data_i[win_idx];
  assign sel_be   = tcdm_be_i[win_idx];
  assign sel_wen  = tcdm_wen_i[win_idx];
  assign offset   = sel_add - BASE_ADDR;
  assign in_range = (sel_add >= BASE_ADDR) && ((offset >> 2) < 32'(MEM_WORDS));
  assign idx      = offset[AW+1:2];
  assign mem_we   = win_valid && !sel_wen && in_range;

  // NOTE: the memory array has no reset; clearing it would only cost logic and the bench preloads what it reads.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[idx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so the read below sees mem before this edge's write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tcdm_r_valid_o <= '0;
      tcdm_r_data_o  <= '0;
      rr_q           <= '0;
      err_o          <= 1'b0;
    end else begin
      tcdm_r_valid_o <= '0;
      if (clear_i) begin
        rr_q  <= '0;
        err_o <= 1'b0;
      end else if (win_valid) begin
        rr_q                    <= (win_idx == PW'(MP - 1)) ? '0 : win_idx + 1'b1;
        tcdm_r_valid_o[win_idx] <= 1'b1;
        tcdm_r_data_o[win_idx]  <= !sel_wen ? '0 : (in_range ? mem[idx] : ERR_DATA);
        if (!in_range) err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_mdc_tcdm_responder.sv
// Bench for sobel_mdc_tcdm_responder: directed scenarios plus random traffic against a queue-free word-array model.
// With TCDM_RESP_STALL_EN defined the model also tracks the stall LFSR and a duty-cycle scenario runs.
module tb_sobel_mdc_tcdm_responder;

  localparam int unsigned MP        = 3;
  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h1000_0000;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear;
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] wdata;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;
  logic                err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]   m_mem [MEM_WORDS];
  logic [31:0]   m_rdata [MP];
  logic [MP-1:0] m_rvalid;
  int            m_rr;
  logic          m_err;
  logic [15:0]   m_lfsr;
  logic [MP-1:0] last_gnt;

  sobel_mdc_tcdm_responder #(.MP(MP), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .ERR_DATA(ERR_DATA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(r_data),
    .tcdm_r_valid_o(r_valid), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic int model_winner();
    logic stall_m;
    stall_m = 1'b0;
`ifdef TCDM_RESP_STALL_EN
    stall_m = (m_lfsr[2:0] == 3'd0);
`endif
    if (!rst_n || clear || stall_m) return -1;
    for (int k = 0; k < int'(MP); k++) begin
      if (req[(m_rr + k) % MP]) return (m_rr + k) % MP;
    end
    return -1;
  endfunction

  task automatic model_update(input int win);
    logic [31:0] a;
    int unsigned i;
    logic inr;
    if (!rst_n) begin
      m_rvalid = '0;
      for (int p = 0; p < int'(MP); p++) m_rdata[p] = '0;
      m_rr   = 0;
      m_err  = 1'b0;
      m_lfsr = 16'hACE1;
    end else begin
      m_lfsr   = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_rvalid = '0;
      if (clear) begin
        m_rr  = 0;
        m_err = 1'b0;
      end else if (win >= 0) begin
        a   = add[win];
        i   = (a - BASE) / 4;
        inr = (a >= BASE) && (i < MEM_WORDS);
        m_rr         = (win + 1) % MP;
        m_rvalid[win] = 1'b1;
        if (wen[win]) m_rdata[win] = inr ? m_mem[i] : ERR_DATA;
        else          m_rdata[win] = '0;
        if (!inr) m_err = 1'b1;
        if (!wen[win] && inr) begin
          for (int b = 0; b < 4; b++)
            if (be[win][b]) m_mem[i][8*b +: 8] = wdata[win][8*b +: 8];
        end
      end
    end
  endtask

  // One clock: check grant at the negedge, advance the model at the posedge, check responses just after.
  task automatic cycle(output int win);
    logic [MP-1:0] exp_gnt;
    @(negedge clk);
    win     = model_winner();
    exp_gnt = '0;
    if (win >= 0) exp_gnt[win] = 1'b1;
    last_gnt = gnt;
    checks++;
    if (gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt: got %b expected %b at %0t", gnt, exp_gnt, $time);
    end
    @(posedge clk);
    model_update(win);
    #1;
    for (int p = 0; p < int'(MP); p++) begin
      checks++;
      if (r_valid[p] !== m_rvalid[p]) begin
        errors++;
        $display("FAIL r_valid[%0d]: got %b expected %b at %0t", p, r_valid[p], m_rvalid[p], $time);
      end
      checks++;
      if (r_data[p] !== m_rdata[p]) begin
        errors++;
        $display("FAIL r_data[%0d]: got %h expected %h at %0t", p, r_data[p], m_rdata[p], $time);
      end
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL err_o: got %b expected %b at %0t", err, m_err, $time);
    end
  endtask

  task automatic idle_inputs();
    req   = '0;
    clear = 1'b0;
    wen   = '1;
    be    = '0;
    add   = '0;
    wdata = '0;
  endtask

  // Hold one request until granted (bounded), then drop it; responses are visible on return.
  task automatic access(input int port, input logic w_en, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int win;
    bit done;
    done        = 1'b0;
    req[port]   = 1'b1;
    wen[port]   = w_en;
    add[port]   = a;
    be[port]    = b;
    wdata[port] = d;
    for (int n = 0; n < 50 && !done; n++) begin
      cycle(win);
      if (win == port) done = 1'b1;
    end
    req[port] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: port %0d got no grant, expected one within 50 cycles", port);
    end
  endtask

  function automatic logic [31:0] window_addr(input int w);
    int unsigned word;
    word = (w < 32) ? w : 1016 + (w - 32);
    return BASE + 32'(4 * word);
  endfunction

  task automatic test_reset();
    int win;
    idle_inputs();
    rst_n = 1'b0;
    req   = '1;
    repeat (2) cycle(win);
    checks++;
    if (r_valid !== '0) begin errors++; $display("FAIL reset_r_valid: got %b expected 0", r_valid); end
    checks++;
    if (r_data !== '0) begin errors++; $display("FAIL reset_r_data: got %h expected 0", r_data); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    req   = '0;
    rst_n = 1'b1;
    cycle(win);
  endtask

  task automatic test_preload();
    for (int w = 0; w < 40; w++) access(0, 1'b0, window_addr(w), 4'hF, $urandom);
  endtask

  task automatic test_single_write_read();
    access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h1234_5678);
    access(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    checks++;
    if (r_valid[0] !== 1'b1 || r_data[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL single_rd: got valid=%b data=%h expected valid=1 data=12345678", r_valid[0], r_data[0]);
    end
  endtask

  task automatic test_byte_enable();
    access(1, 1'b0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    access(1, 1'b0, BASE + 32'h20, 4'b0101, 32'h0);
    access(1, 1'b0, BASE + 32'h20, 4'b0000, 32'h0);
    access(1, 1'b1, BASE + 32'h22, 4'h0, 32'h0);
    checks++;
    if (r_data[1] !== 32'hFF00_FF00) begin
      errors++;
      $display("FAIL byte_enable: got %h expected ff00ff00", r_data[1]);
    end
  endtask

  task automatic test_round_robin();
    int win;
    int seen;
    clear = 1'b1;
    cycle(win);
    clear = 1'b0;
    for (int p = 0; p < int'(MP); p++) begin
      wen[p] = 1'b1;
      add[p] = window_addr(p);
    end
    req  = '1;
    seen = 0;
    for (int n = 0; n < 60 && seen < 6; n++) begin
      cycle(win);
      if (last_gnt != '0) begin
        checks++;
        if (last_gnt !== MP'(1 << (seen % MP))) begin
          errors++;
          $display("FAIL rr_order: grant %0d got %b expected port %0d", seen, last_gnt, seen % MP);
        end
        seen++;
      end
    end
    req = '0;
    checks++;
    if (seen != 6) begin errors++; $display("FAIL rr_count: got %0d grants expected 6", seen); end
  endtask

  task automatic test_out_of_range();
    int win;
    access(2, 1'b0, BASE - 32'd4, 4'hF, 32'hCAFE_F00D);
    access(2, 1'b1, BASE + 32'(4 * MEM_WORDS), 4'h0, 32'h0);
    checks++;
    if (r_data[2] !== ERR_DATA || err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got data=%h err=%b expected data=deadbeef err=1", r_data[2], err);
    end
    clear = 1'b1;
    cycle(win);
    clear = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL oor_clear: got err=%b expected 0", err); end
  endtask

  task automatic test_clear_reset_midop();
    int win;
    access(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    req[0] = 1'b1;
    rst_n  = 1'b0;
    cycle(win);
    checks++;
    if (r_valid !== '0) begin errors++; $display("FAIL reset_midop: got r_valid=%b expected 0", r_valid); end
    rst_n    = 1'b1;
    req      = '0;
    clear    = 1'b1;
    req[0]   = 1'b1;
    wen[0]   = 1'b0;
    add[0]   = BASE + 32'h10;
    be[0]    = 4'hF;
    wdata[0] = 32'h0BAD_0BAD;
    cycle(win);
    req   = '0;
    clear = 1'b0;
    access(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    checks++;
    if (r_data[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL clear_no_write: got %h expected 12345678", r_data[0]);
    end
  endtask

  task automatic test_random();
    int win;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < int'(MP); p++) begin
        req[p]   = $urandom_range(0, 1);
        wen[p]   = $urandom_range(0, 1);
        be[p]    = 4'($urandom);
        wdata[p] = $urandom;
        if ($urandom_range(0, 15) == 0)
          add[p] = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64))
                                               : BASE + 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 255));
        else
          add[p] = window_addr($urandom_range(0, 39)) + 32'($urandom_range(0, 3));
      end
      clear = ($urandom_range(0, 31) == 0);
      cycle(win);
    end
    idle_inputs();
    cycle(win);
  endtask

`ifdef TCDM_RESP_STALL_EN
  task automatic test_stall_duty();
    int win;
    int grants;
    grants = 0;
    req[1] = 1'b1;
    wen[1] = 1'b1;
    add[1] = window_addr(5);
    for (int n = 0; n < 1000; n++) begin
      cycle(win);
      if (last_gnt[1]) grants++;
    end
    req = '0;
    checks++;
    if (grants < 800 || grants > 950) begin
      errors++;
      $display("FAIL stall_duty: got %0d grants in 1000 cycles expected 800..950", grants);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_preload();
    test_single_write_read();
    test_byte_enable();
    test_round_robin();
    test_out_of_range();
    test_clear_reset_midop();
    test_random();
`ifdef TCDM_RESP_STALL_EN
    test_stall_duty();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
